// File: rtl/mc_frame_tx.sv
// Memory-controller frame transmitter: converts one burst request plus a write-data
// stream into sof/eof-marked frame beats, splitting frames at every row boundary.
module mc_frame_tx #(
   parameter int ARRAY_ROW_ADDR   = 14,
   parameter int ARRAY_COL_ADDR   = 6,
   parameter int ARRAY_DATA_WIDTH = 64,
   parameter int FRAME_DATA_WIDTH = 3 + ARRAY_ROW_ADDR + ARRAY_COL_ADDR + ARRAY_DATA_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_rw,
   input  logic [ARRAY_ROW_ADDR-1:0]   req_row,
   input  logic [ARRAY_COL_ADDR-1:0]   req_col,
   input  logic [ARRAY_COL_ADDR-1:0]   req_len,
   input  logic                        wdata_valid,
   output logic                        wdata_ready,
   input  logic [ARRAY_DATA_WIDTH-1:0] wdata,
   output logic                        mc_frame_valid,
   input  logic                        mc_frame_ready,
   output logic [FRAME_DATA_WIDTH-1:0] mc_frame_data,
   output logic                        busy,
   output logic                        burst_done
);

   localparam int REM_W = ARRAY_COL_ADDR + 1;
   localparam logic [ARRAY_ROW_ADDR-1:0] ROW_ONE  = {{(ARRAY_ROW_ADDR-1){1'b0}}, 1'b1};
   localparam logic [ARRAY_COL_ADDR-1:0] COL_ONE  = {{(ARRAY_COL_ADDR-1){1'b0}}, 1'b1};
   localparam logic [ARRAY_COL_ADDR-1:0] COL_LAST = {ARRAY_COL_ADDR{1'b1}};
   localparam logic [REM_W-1:0]          REM_ONE  = {{(REM_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, WR, RD} state_t;

   state_t                      state_q, state_d;
   logic                        alive_q;
   logic [ARRAY_ROW_ADDR-1:0]   row_q;
   logic [ARRAY_COL_ADDR-1:0]   col_q;
   logic [REM_W-1:0]            remain_q;
   logic                        rw_q;
   logic                        sof_q;
   logic                        out_valid_q;
   logic                        out_last_q;
   logic [FRAME_DATA_WIDTH-1:0] out_data_q;

   logic                        req_hs;
   logic                        out_hs;
   logic                        last_hs;
   logic                        load_ok;
   logic                        load;
   logic                        wdata_ready_c;
   logic [ARRAY_ROW_ADDR-1:0]   src_row;
   logic [ARRAY_COL_ADDR-1:0]   src_col;
   logic [REM_W-1:0]            src_remain;
   logic                        src_rw;
   logic                        src_sof;
   logic                        src_eof;
   logic                        src_wrap;
   logic [ARRAY_DATA_WIDTH-1:0] beat_data;

   // In IDLE the beat source is the request itself, so a read issues its first beat
   // on the request handshake; otherwise it is the captured burst cursor.
   always_comb begin
      src_row    = row_q;
      src_col    = col_q;
      src_remain = remain_q;
      src_rw     = rw_q;
      src_sof    = sof_q;
      if (state_q == IDLE) begin
         src_row    = req_row;
         src_col    = req_col;
         src_remain = {1'b0, req_len} + REM_ONE;
         src_rw     = req_rw;
         src_sof    = 1'b1;
      end
      req_hs        = (state_q == IDLE) && alive_q && req_valid;
      out_hs        = out_valid_q && mc_frame_ready;
      last_hs       = out_hs && out_last_q;
      load_ok       = (!out_valid_q || mc_frame_ready) && (src_remain != '0);
      wdata_ready_c = (state_q == WR) && load_ok;
      src_wrap      = (src_col == COL_LAST);
      src_eof       = (src_remain == REM_ONE) || src_wrap;
      beat_data     = src_rw ? wdata : '0;
      load          = 1'b0;
      state_d       = state_q;
      unique case (state_q)
         IDLE: begin
            load = req_hs && !req_rw;
            if (req_hs) state_d = req_rw ? WR : RD;
         end
         WR: begin
            load = wdata_ready_c && wdata_valid;
            if (last_hs) state_d = IDLE;
         end
         RD: begin
            load = load_ok;
            if (last_hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Burst cursor and the single output beat register; a pending beat is held until accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         alive_q     <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
         remain_q    <= '0;
         rw_q        <= 1'b0;
         sof_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
         if (req_hs) begin
            row_q    <= req_row;
            col_q    <= req_col;
            remain_q <= {1'b0, req_len} + REM_ONE;
            rw_q     <= req_rw;
            sof_q    <= 1'b1;
         end
         if (load) begin
            out_valid_q <= 1'b1;
            out_last_q  <= (src_remain == REM_ONE);
            out_data_q  <= {src_sof, src_eof, src_rw, src_row, src_col, beat_data};
            row_q       <= src_wrap ? src_row + ROW_ONE : src_row;
            col_q       <= src_col + COL_ONE;
            remain_q    <= src_remain - REM_ONE;
            sof_q       <= src_wrap;
         end else if (out_hs) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign req_ready      = (state_q == IDLE) && alive_q;
   assign wdata_ready    = wdata_ready_c;
   assign mc_frame_valid = out_valid_q;
   assign mc_frame_data  = out_data_q;
   assign busy           = (state_q != IDLE);
   assign burst_done     = last_hs;

endmodule
